// File: rtl/banco_registradores_sb.sv
// Register bank with one write port and two registered read ports. Writes are
// bypassed to same-cycle reads, and each register has a busy bit for in-order issue.
// Optional feature: define REG0_ZERO_EN to hardwire register 0 to zero.
module banco_registradores_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = (1 << ADDR_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              rd_valid
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic              wr_hit;
  logic              rsv_hit;
  logic [DATA_W-1:0] rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_d;
  logic              busy_a_d;
  logic              busy_b_d;

  // An address is usable if it falls inside the bank (and is not the zero register).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    logic ok;
    ok = (32'(addr) < DEPTH);
`ifdef REG0_ZERO_EN
    ok = ok && (addr != '0);
`endif
    return ok;
  endfunction

  assign wr_hit  = wr_en && addr_ok(wr_addr);
  assign rsv_hit = rsv_en && addr_ok(rsv_addr);

  // Next state of the bank; reserve is applied after the write so it wins on busy.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_hit && (wr_addr == ADDR_W'(i))) begin
        mem_d[i]  = wr_data;
        busy_d[i] = 1'b0;
      end
      if (rsv_hit && (rsv_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  // Reads look at the post-update state, which gives write-first bypass for free.
  always_comb begin
    rd_data_a_d = '0;
    rd_data_b_d = '0;
    busy_a_d    = 1'b0;
    busy_b_d    = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (addr_ok(rd_addr_a) && (rd_addr_a == ADDR_W'(i))) begin
        rd_data_a_d = mem_d[i];
        busy_a_d    = busy_d[i];
      end
      if (addr_ok(rd_addr_b) && (rd_addr_b == ADDR_W'(i))) begin
        rd_data_b_d = mem_d[i];
        busy_b_d    = busy_d[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q    <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      busy_a    <= 1'b0;
      busy_b    <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      busy_q   <= busy_d;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data_a <= rd_data_a_d;
        rd_data_b <= rd_data_b_d;
        busy_a    <= busy_a_d;
        busy_b    <= busy_b_d;
      end
    end
  end

endmodule

// File: tb/tb_banco_registradores_sb.sv
// Scoreboard bench for banco_registradores_sb: reads push expected results, a
// negedge monitor pops and compares whenever rd_valid is presented.
module tb_banco_registradores_sb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 12;

  logic              clock;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_a;
  logic              busy_b;
  logic              rd_valid;

  typedef struct {
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    logic              ba;
    logic              bb;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  banco_registradores_sb #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .rd_valid (rd_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic we, input logic [ADDR_W-1:0] wa,
                     input logic [DATA_W-1:0] wd, input logic rs,
                     input logic [ADDR_W-1:0] ra, input logic re,
                     input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ab);
    @(negedge clock);
    reset     = rst;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rsv_en    = rs;
    rsv_addr  = ra;
    rd_en     = re;
    rd_addr_a = aa;
    rd_addr_b = ab;
  endtask

  task automatic push(input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db,
                      input logic ba, input logic bb);
    exp_t e;
    e.da = da;
    e.db = db;
    e.ba = ba;
    e.bb = bb;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got rd_valid=1, expected no read pending");
        end else begin
          e = exp_q.pop_front();
          chk("rd_data_a", rd_data_a, e.da);
          chk("rd_data_b", rd_data_b, e.db);
          chk("busy_a", 32'(busy_a), 32'(e.ba));
          chk("busy_b", 32'(busy_b), 32'(e.bb));
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] r0_data;
    logic              r0_busy;

    // 1. Reset for two cycles, then read 5 and 15 (15 is out of range here).
    cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    @(posedge clock); #1;
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_rd_data_a", rd_data_a, 32'h0);
    chk("reset_busy_b", 32'(busy_b), 32'h0);
    cyc(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd15);
    push(32'h0, 32'h0, 1'b0, 1'b0);

    // 2. Write then read, then an idle cycle drops rd_valid and holds data.
    cyc(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd4);
    push(32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    idle();
    @(posedge clock); #1;
    chk("idle_rd_valid", 32'(rd_valid), 32'h0);
    chk("idle_hold_data_a", rd_data_a, 32'hDEADBEEF);

    // 3. Both ports bypass the same write.
    cyc(1'b1, 1'b1, 4'd7, 32'h12345678, 1'b0, 4'd0, 1'b1, 4'd7, 4'd7);
    push(32'h12345678, 32'h12345678, 1'b0, 1'b0);

    // 4. Scoreboard: reserve, write clears, write+reserve keeps busy.
    cyc(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b0, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd3);
    push(32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 4'd9, 32'hA5A5A5A5, 1'b0, 4'd0, 1'b1, 4'd9, 4'd7);
    push(32'hA5A5A5A5, 32'h12345678, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'd9, 32'h0BADF00D, 1'b1, 4'd9, 1'b1, 4'd9, 4'd9);
    push(32'h0BADF00D, 32'h0BADF00D, 1'b1, 1'b1);
    // Reserve seen on the same-cycle read; write elsewhere leaves it alone.
    cyc(1'b1, 1'b1, 4'd2, 32'h00000002, 1'b1, 4'd10, 1'b1, 4'd2, 4'd10);
    push(32'h00000002, 32'h0, 1'b0, 1'b1);

    // Out-of-range write/reserve ignored, reads return zero.
    cyc(1'b1, 1'b1, 4'd13, 32'h55555555, 1'b1, 4'd14, 1'b1, 4'd13, 4'd14);
    push(32'h0, 32'h0, 1'b0, 1'b0);

    // 6. Register 0 behaviour.
    cyc(1'b1, 1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0);
`ifdef REG0_ZERO_EN
    r0_data = 32'h0;
    r0_busy = 1'b0;
`else
    r0_data = 32'hFFFFFFFF;
    r0_busy = 1'b1;
`endif
    cyc(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd0, 4'd7);
    push(r0_data, 32'h12345678, r0_busy, 1'b0);

    // 5. Reset during a read discards it and clears the bank.
    cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd9);
    @(posedge clock); #1;
    chk("midrst_rd_valid", 32'(rd_valid), 32'h0);
    chk("midrst_rd_data_a", rd_data_a, 32'h0);
    chk("midrst_rd_data_b", rd_data_b, 32'h0);
    chk("midrst_busy_b", 32'(busy_b), 32'h0);
    cyc(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd9);
    push(32'h0, 32'h0, 1'b0, 1'b0);

    idle();
    idle();
    @(negedge clock); #1;
    chk("pending_reads", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
